jtag_user_dr: RTL and testbench

Parametrised multi-chain user data register for the JTAG TAP data path. It holds `NCHAIN` user chains of `WIDTH` bits behind one shared shift register, and keeps a 1-bit bypass path for when no user chain is selected. All capture, shift and update actions run on `tck` through enables rather than gated `clkDR`/`updateDR` clocks. Unlike the fixed-length registers, it counts shifted bits and commits an update only when exactly `WIDTH` bits were shifted.

---
 rtl/jtag_dr_pkg.sv | 14 +
 rtl/user_dr_latch.sv | 32 +++
 rtl/jtag_user_dr.sv | 116 +++++++++++
 tb/tb_jtag_user_dr.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/jtag_dr_pkg.sv
// Shared types and sizing helpers for the JTAG user data register.
package jtag_dr_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } dr_state_t;

    // Counter must reach WIDTH+1 so that over-length shifts stay distinguishable.
    function automatic int cnt_w(input int width);
        return $clog2(width + 2);
    endfunction

endpackage

// File: rtl/user_dr_latch.sv
// Per-chain update latch: holds the committed word and pulses a strobe
// for the single tck cycle after each commit.
module user_dr_latch #(
    parameter int WIDTH = 8
) (
    input  logic             tck,
    input  logic             reset_n,
    input  logic             commit,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             strobe
);

    logic [WIDTH-1:0] r_q;
    logic             r_strobe;

    always_ff @(posedge tck or negedge reset_n) begin
        if (!reset_n) begin
            r_q      <= '0;
            r_strobe <= 1'b0;
        end else begin
            r_strobe <= commit;
            if (commit) begin
                r_q <= d;
            end
        end
    end

    assign q      = r_q;
    assign strobe = r_strobe;

endmodule

// File: rtl/jtag_user_dr.sv
// Multi-chain JTAG user data register with bypass and exact-length update
// checking; all actions run on tck through capture/shift/update enables.
module jtag_user_dr
    import jtag_dr_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int NCHAIN    = 4,
    parameter int CHECK_LEN = 1,
    parameter int SELW      = (NCHAIN > 1) ? $clog2(NCHAIN) : 1
) (
    input  logic                     tck,
    input  logic                     reset_n,
    input  logic                     capture_dr,
    input  logic                     shift_dr,
    input  logic                     update_dr,
    input  logic [SELW-1:0]          chain_sel,
    input  logic                     chain_valid,
    input  logic                     tdi,
    output logic                     tdo,
    input  logic [NCHAIN*WIDTH-1:0]  cap_data,
    output logic [NCHAIN*WIDTH-1:0]  upd_data,
    output logic [NCHAIN-1:0]        upd_strobe,
    output logic                     len_err
);

    localparam int             CNT_W    = cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(WIDTH + 1);

    dr_state_t        r_state;
    logic [WIDTH-1:0] r_sr;
    logic             r_byp;
    logic [SELW-1:0]  r_sel;
    logic             r_use_byp;
    logic [CNT_W-1:0] r_cnt;
    logic             r_len_err;

    logic [WIDTH-1:0]  w_cap_word;
    logic              w_cap_hit;
    logic              w_do_shift;
    logic              w_do_update;
    logic              w_len_ok;
    logic [NCHAIN-1:0] w_commit;

    // An index with no matching chain leaves w_cap_hit low and falls back to bypass.
    always_comb begin
        w_cap_word = '0;
        w_cap_hit  = 1'b0;
        for (int n = 0; n < NCHAIN; n++) begin
            if (chain_sel == SELW'(n)) begin
                w_cap_word = cap_data[n*WIDTH +: WIDTH];
                w_cap_hit  = 1'b1;
            end
        end
    end

    assign w_do_shift  = shift_dr & ~capture_dr & (r_state == ARMED);
    assign w_do_update = update_dr & ~capture_dr & ~shift_dr & (r_state == ARMED);
    assign w_len_ok    = (r_cnt == CNT_FULL) || (CHECK_LEN == 0);

    always_ff @(posedge tck or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_sr      <= '0;
            r_byp     <= 1'b0;
            r_sel     <= '0;
            r_use_byp <= 1'b0;
            r_cnt     <= '0;
            r_len_err <= 1'b0;
        end else if (capture_dr) begin
            r_sel     <= chain_sel;
            r_use_byp <= ~chain_valid | ~w_cap_hit;
            r_sr      <= w_cap_word;
            r_byp     <= 1'b0;
            r_cnt     <= '0;
            r_len_err <= 1'b0;
            r_state   <= ARMED;
        end else if (w_do_shift) begin
            if (r_use_byp) begin
                r_byp <= tdi;
            end else begin
                r_sr <= {tdi, r_sr[WIDTH-1:1]};
            end
            if (r_cnt != CNT_SAT) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end else if (w_do_update) begin
            if (!r_use_byp && !w_len_ok) begin
                r_len_err <= 1'b1;
            end
            r_state <= IDLE;
        end
    end

    genvar g;
    generate
        for (g = 0; g < NCHAIN; g++) begin : g_chain
            assign w_commit[g] = w_do_update & ~r_use_byp & w_len_ok & (r_sel == SELW'(g));

            user_dr_latch #(
                .WIDTH (WIDTH)
            ) u_latch (
                .tck     (tck),
                .reset_n (reset_n),
                .commit  (w_commit[g]),
                .d       (r_sr),
                .q       (upd_data[g*WIDTH +: WIDTH]),
                .strobe  (upd_strobe[g])
            );
        end
    endgenerate

    assign tdo     = r_use_byp ? r_byp : r_sr[0];
    assign len_err = r_len_err;

endmodule

// File: tb/tb_jtag_user_dr.sv
// Randomised bench for jtag_user_dr: two instances (length-checked and not)
// are compared each cycle against a transaction-level reference model.
module tb_jtag_user_dr;

    logic        tck = 1'b0;
    logic        reset_n;
    logic        capture_dr, shift_dr, update_dr;
    logic [1:0]  chain_sel;
    logic        chain_valid;
    logic        tdi;
    logic [31:0] cap_data;

    logic        tdo_c, tdo_n;
    logic [31:0] upd_c, upd_n;
    logic [3:0]  stb_c, stb_n;
    logic        err_c, err_n;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    bit          m_armed, m_bmode, m_bbit;
    int          m_sel, m_cnt;
    logic [7:0]  m_word;
    logic [31:0] m_upd_c, m_upd_n;
    logic [3:0]  m_stb_c, m_stb_n;
    bit          m_err_c;

    always #5 tck = ~tck;

    jtag_user_dr #(.WIDTH(8), .NCHAIN(4), .CHECK_LEN(1)) dut (
        .tck(tck), .reset_n(reset_n), .capture_dr(capture_dr), .shift_dr(shift_dr),
        .update_dr(update_dr), .chain_sel(chain_sel), .chain_valid(chain_valid),
        .tdi(tdi), .tdo(tdo_c), .cap_data(cap_data), .upd_data(upd_c),
        .upd_strobe(stb_c), .len_err(err_c)
    );

    jtag_user_dr #(.WIDTH(8), .NCHAIN(4), .CHECK_LEN(0)) dut_nc (
        .tck(tck), .reset_n(reset_n), .capture_dr(capture_dr), .shift_dr(shift_dr),
        .update_dr(update_dr), .chain_sel(chain_sel), .chain_valid(chain_valid),
        .tdi(tdi), .tdo(tdo_n), .cap_data(cap_data), .upd_data(upd_n),
        .upd_strobe(stb_n), .len_err(err_n)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_armed = 0; m_bmode = 0; m_bbit = 0;
        m_sel = 0; m_cnt = 0; m_word = '0;
        m_upd_c = '0; m_upd_n = '0;
        m_stb_c = '0; m_stb_n = '0;
        m_err_c = 0;
    endtask

    // One tck edge of behaviour, applying capture > shift > update priority.
    task automatic model_edge();
        m_stb_c = '0;
        m_stb_n = '0;
        if (capture_dr) begin
            m_sel   = int'(chain_sel);
            m_bmode = !chain_valid;
            m_word  = cap_data[m_sel*8 +: 8];
            m_bbit  = 0;
            m_cnt   = 0;
            m_err_c = 0;
            m_armed = 1;
        end else if (shift_dr && m_armed) begin
            if (m_bmode) m_bbit = tdi;
            else         m_word = (m_word >> 1) | (8'(tdi) << 7);
            m_cnt = (m_cnt + 1 > 9) ? 9 : m_cnt + 1;
        end else if (update_dr && m_armed) begin
            m_armed = 0;
            if (!m_bmode) begin
                m_upd_n[m_sel*8 +: 8] = m_word;
                m_stb_n[m_sel] = 1'b1;
                if (m_cnt == 8) begin
                    m_upd_c[m_sel*8 +: 8] = m_word;
                    m_stb_c[m_sel] = 1'b1;
                end else begin
                    m_err_c = 1;
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        logic exp_tdo;
        exp_tdo = m_bmode ? m_bbit : m_word[0];
        chk({tag, ".tdo"},     32'(tdo_c), 32'(exp_tdo));
        chk({tag, ".upd"},     upd_c,      m_upd_c);
        chk({tag, ".stb"},     32'(stb_c), 32'(m_stb_c));
        chk({tag, ".err"},     32'(err_c), 32'(m_err_c));
        chk({tag, ".nc_tdo"},  32'(tdo_n), 32'(exp_tdo));
        chk({tag, ".nc_upd"},  upd_n,      m_upd_n);
        chk({tag, ".nc_stb"},  32'(stb_n), 32'(m_stb_n));
        chk({tag, ".nc_err"},  32'(err_n), 32'd0);
    endtask

    task automatic tick(input string tag, input bit c, input bit s, input bit u, input bit d);
        capture_dr = c;
        shift_dr   = s;
        update_dr  = u;
        tdi        = d;
        @(posedge tck);
        #1;
        if (!reset_n) model_reset();
        else          model_edge();
        check_all(tag);
    endtask

    task automatic shift_word(input string tag, input int n, input logic [15:0] bits);
        for (int i = 0; i < n; i++) begin
            tick(tag, 0, 1, 0, bits[i]);
        end
    endtask

    initial begin
        // Reset with garbage on every input
        reset_n = 0; capture_dr = 1; shift_dr = 1; update_dr = 1;
        chain_sel = 2'd3; chain_valid = 1; tdi = 1; cap_data = 32'hDEAD_BEEF;
        model_reset();
        repeat (3) @(posedge tck);
        #1;
        check_all("reset");
        #3 reset_n = 1;
        tick("upd_no_cap", 0, 0, 1, 0);

        // Exact-length shift into chain 2
        chain_sel = 2'd2; chain_valid = 1; cap_data = 32'h11A5_2233;
        tick("exact.cap", 1, 0, 0, 0);
        shift_word("exact.sh", 8, 16'h003C);
        tick("exact.upd", 0, 0, 1, 0);
        chk("exact.upd2_const", 32'(upd_c[23:16]), 32'h3C);
        chk("exact.stb_const",  32'(stb_c),        32'h4);
        tick("exact.drop", 0, 0, 0, 0);

        // Short then long shift
        cap_data = 32'h5A5A_5A5A;
        tick("short.cap", 1, 0, 0, 0);
        shift_word("short.sh", 7, 16'h00F0);
        tick("short.upd", 0, 0, 1, 0);
        chk("short.err_const", 32'(err_c), 32'h1);
        tick("long.cap", 1, 0, 0, 0);
        shift_word("long.sh", 9, 16'h01C3);
        tick("long.upd", 0, 0, 1, 0);
        tick("long.idle", 0, 0, 0, 0);

        // Bypass
        chain_valid = 0;
        tick("byp.cap", 1, 0, 0, 0);
        shift_word("byp.sh", 3, 16'h0003);
        tick("byp.upd", 0, 0, 1, 0);

        // Reset in the middle of a shift
        chain_valid = 1; chain_sel = 2'd1; cap_data = 32'hFFFF_FFFF;
        tick("rstmid.cap", 1, 0, 0, 0);
        shift_word("rstmid.sh", 4, 16'h000F);
        #2 reset_n = 0;
        #1 model_reset();
        check_all("rstmid.async");
        #3 reset_n = 1;
        shift_word("rstmid.after", 3, 16'h0007);
        tick("rstmid.upd", 0, 0, 1, 0);

        // Conflicting enables, then selection change mid-shift
        chain_sel = 2'd0; cap_data = 32'h0000_0081;
        tick("conf.cap", 1, 0, 0, 0);
        shift_word("conf.sh", 8, 16'h0055);
        tick("conf.capupd", 1, 0, 1, 0);
        tick("conf.idle", 0, 0, 0, 0);
        chain_sel = 2'd2; cap_data = 32'h0096_0000;
        tick("selchg.cap", 1, 0, 0, 0);
        shift_word("selchg.sh1", 4, 16'h000A);
        chain_sel = 2'd1;
        shift_word("selchg.sh2", 4, 16'h0005);
        tick("selchg.upd", 0, 0, 1, 0);
        chk("selchg.stb_const", 32'(stb_c), 32'h4);

        // Random transactions with occasional illegal enable mixes
        for (int t = 0; t < 150; t++) begin
            int nsh;
            chain_sel   = 2'($urandom_range(0, 3));
            chain_valid = ($urandom_range(0, 4) != 0);
            cap_data    = $urandom;
            tick("rnd.cap", 1, 0, 0, 0);
            nsh = $urandom_range(6, 10);
            for (int i = 0; i < nsh; i++) begin
                chain_sel = 2'($urandom_range(0, 3));
                cap_data  = $urandom;
                if ($urandom_range(0, 19) == 0)
                    tick("rnd.mix", 1'($urandom), 1, 1'($urandom), 1'($urandom));
                else
                    tick("rnd.sh", 0, 1, 0, 1'($urandom));
            end
            tick("rnd.upd", 0, 0, 1, 0);
            repeat ($urandom_range(0, 2)) tick("rnd.idle", 0, 1'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
